// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule engine: size derivation,
// round-constant seed, GF(2^8) doubling and the controller state type.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return nk_of(key_bits) + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry x lives at bits [8*(255-x)+7 -: 8], i.e. index {~x, 3'b111}.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = TABLE[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES key expansion, one schedule word per valid/ready handshake.
// Define KEYEXP_ABORT_EN to add the abort input.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | presenting w[i] until the last word is accepted
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
`ifdef KEYEXP_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [31:0]         word,
    output logic [5:0]          word_idx,
    output logic                word_last,
    output logic                done
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  m_q, m_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic        load, shift, run;
    logic [31:0] win_q [NK];
    logic [31:0] prev, sub_in, sub_out, temp, next_word;

    // win_q[0] is always w[i-NK] (or key word i early on), win_q[NK-1] is w[i-1].
    assign prev   = win_q[NK-1];
    assign sub_in = (m_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev;
        if (m_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && m_q == 3'd4) begin
            temp = sub_out;
        end
    end

    assign next_word  = (i_q < 6'(NK)) ? win_q[0] : (win_q[0] ^ temp);
    assign run        = (state_q == RUN);
    assign busy       = run;
    assign word_valid = run;
    assign word       = run ? next_word : 32'h0;
    assign word_idx   = i_q;
    assign word_last  = run && (i_q == 6'(NW-1));
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        m_d     = m_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                // the done cycle still counts as busy for start purposes
                if (start && !done_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                    i_d     = 6'd0;
                    m_d     = 3'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            RUN: begin
`ifdef KEYEXP_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                    i_d     = 6'd0;
                    m_d     = 3'd0;
                    rcon_d  = RCON_INIT;
                end else
`endif
                if (word_ready) begin
                    shift = 1'b1;
                    if (i_q == 6'(NW-1)) begin
                        state_d = IDLE;
                        i_d     = 6'd0;
                        m_d     = 3'd0;
                        rcon_d  = RCON_INIT;
                        done_d  = 1'b1;
                    end else begin
                        i_d = i_q + 6'd1;
                        m_d = (m_q == 3'(NK-1)) ? 3'd0 : m_q + 3'd1;
                        if (i_q >= 6'(NK) && m_q == 3'd0) begin
                            rcon_d = xtime(rcon_q);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 6'd0;
            m_q     <= 3'd0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            m_q     <= m_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= 32'h0;
            end
        end else if (load) begin
            for (int j = 0; j < NK; j++) begin
                win_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
            end
        end else if (shift) begin
            for (int j = 0; j < NK-1; j++) begin
                win_q[j] <= win_q[j+1];
            end
            win_q[NK-1] <= next_word;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench: AES-128/192/256 instances against a GF(2^8)-derived reference schedule.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]   start_r, ready_r, abort_r;
    logic [2:0]   busy_w, valid_w, last_w, done_w;
    logic [255:0] key_r [3];
    logic [31:0]  word_w [3];
    logic [5:0]   idx_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB = 128 + 64*g;
        aes_key_expand #(.KEY_BITS(KB)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_r[g]),
            .key_in     (key_r[g][KB-1:0]),
`ifdef KEYEXP_ABORT_EN
            .abort      (abort_r[g]),
`endif
            .busy       (busy_w[g]),
            .word_valid (valid_w[g]),
            .word_ready (ready_r[g]),
            .word       (word_w[g]),
            .word_idx   (idx_w[g]),
            .word_last  (last_w[g]),
            .done       (done_w[g])
        );
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];
    localparam int HSN [3] = '{44, 52, 60};

    localparam logic [255:0] K128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] a, input int e);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < e; k++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // FIPS-197 key expansion; rcon for round r is 2^(r-1) in GF(2^8).
    function automatic logic [31:0] ref_word(input logic [255:0] k, input int nk, input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < nk; i++) w[i] = k[32*(nk-i)-1 -: 32];
        for (int i = nk; i <= idx; i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {gpow(8'h02, i/nk - 1), 24'h0};
            else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        return w[idx];
    endfunction

    // Reference model state and the single compare process.
    bit           act [3];
    bit           edone [3];
    bit           dn_next;
    int           ei [3];
    int           hs [3];
    logic [255:0] ekey [3];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                chk($sformatf("rst_valid%0d", g), valid_w[g], 0);
                chk($sformatf("rst_busy%0d", g), busy_w[g], 0);
                chk($sformatf("rst_done%0d", g), done_w[g], 0);
                chk($sformatf("rst_word%0d", g), word_w[g], 0);
                chk($sformatf("rst_idx%0d", g), idx_w[g], 0);
                chk($sformatf("rst_last%0d", g), last_w[g], 0);
                act[g] = 0; edone[g] = 0; hs[g] = 0; ei[g] = 0;
            end else begin
                dn_next = 0;
                chk($sformatf("busy%0d", g), busy_w[g], act[g]);
                chk($sformatf("valid%0d", g), valid_w[g], act[g]);
                chk($sformatf("done%0d", g), done_w[g], edone[g]);
                if (act[g]) begin
                    chk($sformatf("idx%0d", g), idx_w[g], ei[g]);
                    chk($sformatf("word%0d[%0d]", g, ei[g]), word_w[g], ref_word(ekey[g], 4 + 2*g, ei[g]));
                    chk($sformatf("last%0d[%0d]", g, ei[g]), last_w[g], ei[g] == HSN[g] - 1);
                end
                if (done_w[g]) chk($sformatf("handshakes%0d", g), hs[g], HSN[g]);
                if (valid_w[g] && ready_r[g]) hs[g]++;
                if (act[g]) begin
                    if (abort_r[g]) begin
                        act[g] = 0; hs[g] = 0;
                    end else if (ready_r[g]) begin
                        if (ei[g] == HSN[g] - 1) begin
                            act[g] = 0; dn_next = 1;
                        end else begin
                            ei[g]++;
                        end
                    end
                end else if (start_r[g] && !edone[g]) begin
                    act[g] = 1; ei[g] = 0; ekey[g] = key_r[g]; hs[g] = 0;
                end
                edone[g] = dn_next;
            end
        end
    end

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input int g, input logic [255:0] k);
        @(posedge clk); #2;
        key_r[g] = k;
        start_r[g] = 1'b1;
        @(posedge clk); #2;
        start_r[g] = 1'b0;
    endtask

    task automatic wait_idx(input int g, input int idx);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            if (valid_w[g] && idx_w[g] == 6'(idx)) return;
        end
        fail_timeout($sformatf("wait_idx%0d_%0d", g, idx));
    endtask

    task automatic wait_done(input int g);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            if (done_w[g]) return;
        end
        fail_timeout($sformatf("wait_done%0d", g));
    endtask

    task automatic run_rand(input int g);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #2;
            if (done_w[g]) begin
                ready_r[g] = 1'b1;
                return;
            end
            ready_r[g] = ($urandom_range(0, 3) != 0);
        end
        ready_r[g] = 1'b1;
        fail_timeout($sformatf("run_rand%0d", g));
    endtask

    initial begin
        logic [7:0] inv;
        rst = 1'b1;
        start_r = '0;
        ready_r = '1;
        abort_r = '0;
        for (int g = 0; g < 3; g++) key_r[g] = '0;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : gpow(8'(x), 254);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        chk("model_sbox_00", sb[8'h00], 8'h63);
        chk("model_sbox_53", sb[8'h53], 8'hed);
        chk("model_128_w4", ref_word(K128, 4, 4), 32'ha0fafe17);
        chk("model_128_w43", ref_word(K128, 4, 43), 32'hb6630ca6);
        chk("model_192_w6", ref_word(K192, 6, 6), 32'hfe0c91f7);
        chk("model_192_w51", ref_word(K192, 6, 51), 32'h01002202);
        chk("model_256_w8", ref_word(K256, 8, 8), 32'h9ba35411);
        chk("model_256_w12", ref_word(K256, 8, 12), 32'ha8b09c1a);
        chk("model_256_w59", ref_word(K256, 8, 59), 32'h706c631e);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        do_start(0, K128); wait_done(0);
        do_start(1, K192); wait_done(1);
        do_start(2, K256); wait_done(2);

        do_start(0, K128);
        wait_idx(0, 10);
        ready_r[0] = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        ready_r[0] = 1'b1;
        wait_done(0);

        do_start(0, K128);
        wait_idx(0, 5);
        key_r[0] = rand_key();
        start_r[0] = 1'b1;
        @(posedge clk); #2;
        start_r[0] = 1'b0;
        wait_done(0);

        do_start(0, K128);
        wait_idx(0, 20);
        rst = 1'b1;
        #1;
        chk("rst_now_valid", valid_w[0], 0);
        chk("rst_now_busy", busy_w[0], 0);
        chk("rst_now_word", word_w[0], 0);
        chk("rst_now_idx", idx_w[0], 0);
        chk("rst_now_last", last_w[0], 0);
        @(posedge clk); #2;
        rst = 1'b0;
        do_start(0, rand_key()); wait_done(0);

        do_start(1, K192);
        wait_done(1);
        key_r[1] = rand_key();
        start_r[1] = 1'b1;
        @(posedge clk); #2;
        start_r[1] = 1'b0;
        chk("start_in_done_ignored", busy_w[1], 0);
        repeat (2) @(posedge clk);

`ifdef KEYEXP_ABORT_EN
        do_start(0, K128);
        wait_idx(0, 20);
        abort_r[0] = 1'b1;
        ready_r[0] = 1'b1;
        @(posedge clk); #2;
        abort_r[0] = 1'b0;
        chk("abort_busy", busy_w[0], 0);
        chk("abort_valid", valid_w[0], 0);
        repeat (3) begin @(posedge clk); #2; chk("abort_no_done", done_w[0], 0); end
        do_start(0, K128); wait_done(0);
`endif

        for (int n = 0; n < 6; n++) begin
            int g;
            g = $urandom_range(0, 2);
            do_start(g, rand_key());
            run_rand(g);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
